// File: rtl/tsg_serial_multiplier_if.sv
// Request/response bundle between a requester and the phase-driven serial multiplier.
interface tsg_serial_multiplier_if;
    logic        start;
    logic [7:0]  a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [15:0] product;
    logic        phase_err;

    modport master (
        output start, a, b,
        input  busy, done, product, phase_err
    );

    modport slave (
        input  start, a, b,
        output busy, done, product, phase_err
    );
endinterface

// File: rtl/tsg_serial_multiplier.sv
// 8x8 unsigned shift-add multiplier stepped by the one-hot phase bus T[7:0];
// phase T[i] performs partial-product step i, one rotation per product.
module tsg_serial_multiplier (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [7:0]                    T,
    tsg_serial_multiplier_if.slave        bus
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ARMED = 2'd1;
    localparam logic [1:0] S_RUN   = 2'd2;
    localparam logic [1:0] S_DONE  = 2'd3;

    logic [1:0]  r_state;
    logic [7:0]  r_a;
    logic [7:0]  r_b;
    logic [15:0] r_acc;
    logic [2:0]  r_idx;
    logic [15:0] r_product;
    logic        r_err;

    logic [15:0] w_term;
    logic [15:0] w_sum;
    logic        w_match;

    // r_idx is zero in ARMED, so the same adder serves step 0 and the RUN steps
    assign w_term  = r_b[r_idx] ? ({8'b0, r_a} << r_idx) : 16'd0;
    assign w_sum   = r_acc + w_term;
    assign w_match = (T == (8'd1 << r_idx));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= S_IDLE;
            r_a       <= 8'd0;
            r_b       <= 8'd0;
            r_acc     <= 16'd0;
            r_idx     <= 3'd0;
            r_product <= 16'd0;
            r_err     <= 1'b0;
        end else begin
            unique case (r_state)
                S_IDLE, S_DONE: begin
                    if (bus.start) begin
                        r_a     <= bus.a;
                        r_b     <= bus.b;
                        r_acc   <= 16'd0;
                        r_idx   <= 3'd0;
                        r_err   <= 1'b0;
                        r_state <= S_ARMED;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
                S_ARMED: begin
                    if (T == 8'h01) begin
                        r_acc   <= w_sum;
                        r_idx   <= 3'd1;
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (w_match) begin
                        r_acc <= w_sum;
                        r_idx <= r_idx + 3'd1;
                        if (r_idx == 3'd7) begin
                            r_product <= w_sum;
                            r_state   <= S_DONE;
                        end
                    end else begin
                        r_err   <= 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

    assign bus.busy      = (r_state == S_ARMED) || (r_state == S_RUN);
    assign bus.done      = (r_state == S_DONE);
    assign bus.product   = r_product;
    assign bus.phase_err = r_err;
endmodule

// File: tb/tb_tsg_serial_multiplier.sv
// Directed bench for tsg_serial_multiplier with a modelled phase generator
// and a product scoreboard popped on every done pulse.
module tb_tsg_serial_multiplier;
    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic [7:0] T = 8'h01;
    logic [2:0] ph = 3'd0;
    logic       skip = 1'b0;

    int nvec = 0;
    int nerr = 0;
    logic [15:0] q[$];

    tsg_serial_multiplier_if bus ();

    tsg_serial_multiplier dut (
        .clk   (clk),
        .reset (reset),
        .T     (T),
        .bus   (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs,
                         input logic [31:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // advance one clock; inputs change and outputs are sampled 1ns after the edge
    task automatic cyc();
        @(posedge clk);
        #1;
        ph = ph + (skip ? 3'd2 : 3'd1);
        T = 8'd1 << ph;
        if (bus.done) begin
            if (q.size() == 0)
                check("spurious_done", 32'd1, 32'd0);
            else
                check("product", {16'd0, bus.product}, {16'd0, q.pop_front()});
        end
    endtask

    task automatic wait_ph(input logic [2:0] p);
        for (int i = 0; i < 8 && ph != p; i++) cyc();
    endtask

    task automatic do_op(input logic [7:0] ia, input logic [7:0] ib);
        int k;
        int w;
        w = (7 - int'(ph)) & 7;
        bus.start = 1'b1;
        bus.a = ia;
        bus.b = ib;
        q.push_back(16'(ia) * 16'(ib));
        cyc();
        bus.start = 1'b0;
        bus.a = 8'hA5;
        bus.b = 8'h5A;
        k = 1;
        while (!bus.done && k < 30) begin
            check("busy_run", {31'd0, bus.busy}, 32'd1);
            cyc();
            k++;
        end
        check("latency", k, 9 + w);
        check("busy_done", {31'd0, bus.busy}, 32'd0);
    endtask

    initial begin
        int k;
        bus.start = 1'b0;
        bus.a = 8'd0;
        bus.b = 8'd0;

        cyc();
        cyc();
        check("rst_busy", {31'd0, bus.busy}, 32'd0);
        check("rst_done", {31'd0, bus.done}, 32'd0);
        check("rst_product", {16'd0, bus.product}, 32'd0);
        check("rst_err", {31'd0, bus.phase_err}, 32'd0);
        reset = 1'b0;
        repeat (20) cyc();
        check("idle_busy", {31'd0, bus.busy}, 32'd0);
        check("idle_product", {16'd0, bus.product}, 32'd0);
        check("idle_err", {31'd0, bus.phase_err}, 32'd0);

        wait_ph(3'd3);
        check("t08", {24'd0, T}, 32'h08);
        do_op(8'd13, 8'd11);
        do_op(8'd255, 8'd255);
        check("max_product", {16'd0, bus.product}, 32'hFE01);
        wait_ph(3'd0);
        do_op(8'd200, 8'd0);
        check("zero_product", {16'd0, bus.product}, 32'd0);
        do_op(8'd37, 8'd129);

        // phase fault: skip T[3] after T[2]
        wait_ph(3'd7);
        bus.start = 1'b1;
        bus.a = 8'd6;
        bus.b = 8'd7;
        cyc();
        bus.start = 1'b0;
        cyc();
        cyc();
        check("fault_pre_t", {24'd0, T}, 32'h04);
        skip = 1'b1;
        cyc();
        skip = 1'b0;
        check("fault_t", {24'd0, T}, 32'h10);
        check("fault_busy_before", {31'd0, bus.busy}, 32'd1);
        cyc();
        check("fault_err", {31'd0, bus.phase_err}, 32'd1);
        check("fault_busy", {31'd0, bus.busy}, 32'd0);
        check("fault_done", {31'd0, bus.done}, 32'd0);
        check("fault_product", {16'd0, bus.product}, 32'd4773);
        repeat (10) cyc();
        check("fault_sticky", {31'd0, bus.phase_err}, 32'd1);
        bus.start = 1'b1;
        bus.a = 8'd2;
        bus.b = 8'd3;
        q.push_back(16'd6);
        cyc();
        bus.start = 1'b0;
        check("err_cleared", {31'd0, bus.phase_err}, 32'd0);
        for (k = 1; !bus.done && k < 30; k++) cyc();
        check("after_fault_done", {31'd0, bus.done}, 32'd1);

        // start held high through a whole operation, then back-to-back
        wait_ph(3'd5);
        bus.start = 1'b1;
        bus.a = 8'd3;
        bus.b = 8'd5;
        q.push_back(16'd15);
        cyc();
        bus.a = 8'd7;
        bus.b = 8'd9;
        q.push_back(16'd63);
        for (k = 1; !bus.done && k < 30; k++) cyc();
        check("hs_lat1", k, 11);
        check("hs_t0_at_done", {24'd0, T}, 32'h01);
        cyc();
        bus.start = 1'b0;
        check("hs_rearmed", {31'd0, bus.busy}, 32'd1);
        for (k = 1; !bus.done && k < 30; k++) cyc();
        check("hs_lat2", k, 16);
        check("hs_product", {16'd0, bus.product}, 32'd63);

        // reset during the T[5] cycle
        wait_ph(3'd7);
        bus.start = 1'b1;
        bus.a = 8'd9;
        bus.b = 8'd9;
        cyc();
        bus.start = 1'b0;
        repeat (5) cyc();
        check("mid_t5", {24'd0, T}, 32'h20);
        reset = 1'b1;
        cyc();
        reset = 1'b0;
        check("mr_busy", {31'd0, bus.busy}, 32'd0);
        check("mr_product", {16'd0, bus.product}, 32'd0);
        check("mr_done", {31'd0, bus.done}, 32'd0);
        repeat (20) cyc();
        check("mr_idle", {31'd0, bus.busy}, 32'd0);
        check("queue_empty", q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule
